// File: rtl/jk_bank_arbiter_pkg.sv
// jk_arb_pkg: shared JK op encoding for the JK bank arbiter.
package jk_arb_pkg;

    typedef logic [1:0] jk_op_t;

    localparam jk_op_t JK_HOLD = 2'b00;
    localparam jk_op_t JK_RST  = 2'b01;
    localparam jk_op_t JK_SET  = 2'b10;
    localparam jk_op_t JK_TGL  = 2'b11;

endpackage

// File: rtl/jk_bank_arbiter_if.sv
// jk_bank_arbiter_if: requester command bus plus bank status outputs.
// master = requester side, slave = arbiter side.
interface jk_bank_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int NUM_FF  = 8
);
    localparam int IDX_W = $clog2(NUM_FF);
    localparam int REQ_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*IDX_W-1:0] req_idx;
    logic [NUM_REQ*2-1:0]     req_op;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_FF-1:0]        q;
    logic                     grant_vld;
    logic [REQ_W-1:0]         grant_id;
    logic                     err_oor;

    modport master (
        output req_valid, req_idx, req_op,
        input  req_ready, q, grant_vld, grant_id, err_oor
    );

    modport slave (
        input  req_valid, req_idx, req_op,
        output req_ready, q, grant_vld, grant_id, err_oor
    );

endinterface

// File: rtl/jk_bank_arbiter_cell.sv
// jk_cell: one JK flip-flop with enable and synchronous active-high reset.
module jk_cell
    import jk_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic j,
    input  logic k,
    output logic q
);

    logic r_q;

    // JK state update, only when this cell is addressed
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= 1'b0;
        end else if (en) begin
            case ({j, k})
                JK_RST:  r_q <= 1'b0;
                JK_SET:  r_q <= 1'b1;
                JK_TGL:  r_q <= ~r_q;
                default: r_q <= r_q;
            endcase
        end
    end

    assign q = r_q;

endmodule

// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter: shares a bank of NUM_FF JK cells between NUM_REQ
// requesters, one accepted command per cycle.
// Build option: JK_ARB_FIXED_PRIO_EN selects fixed priority (requester 0
// highest) instead of round-robin; the rotating pointer is then absent.
module jk_bank_arbiter
    import jk_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int NUM_FF  = 8
) (
    input  logic             clk,
    input  logic             rst,
    jk_bank_arbiter_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_FF);
    localparam int REQ_W = $clog2(NUM_REQ);

    logic               w_win_vld;
    logic [REQ_W-1:0]   w_win_id;
    logic [IDX_W-1:0]   w_idx;
    jk_op_t             w_op;
    logic               w_oor;
    logic [NUM_FF-1:0]  w_en;
    logic [NUM_FF-1:0]  w_q;

    logic               r_grant_vld;
    logic [REQ_W-1:0]   r_grant_id;
    logic               r_err_oor;

`ifdef JK_ARB_FIXED_PRIO_EN
    // Winner select: lowest-numbered valid requester; held off during reset
    always_comb begin
        w_win_vld = 1'b0;
        w_win_id  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_win_vld && bus.req_valid[i]) begin
                w_win_vld = 1'b1;
                w_win_id  = REQ_W'(i);
            end
        end
        if (rst) w_win_vld = 1'b0;
    end
`else
    logic [REQ_W-1:0] r_rr_ptr;

    // Requester id i slots after the pointer, wrapping at NUM_REQ
    function automatic logic [REQ_W-1:0] rr_slot(input logic [REQ_W-1:0] ptr, input int i);
        int s;
        s = (int'(ptr) + i) % NUM_REQ;
        return REQ_W'(s);
    endfunction

    // Winner select: first valid requester scanning from the pointer
    always_comb begin
        w_win_vld = 1'b0;
        w_win_id  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_win_vld && bus.req_valid[rr_slot(r_rr_ptr, i)]) begin
                w_win_vld = 1'b1;
                w_win_id  = rr_slot(r_rr_ptr, i);
            end
        end
        if (rst) w_win_vld = 1'b0;
    end

    // Pointer moves just past the winner; idle cycles leave it alone
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_win_vld) begin
            r_rr_ptr <= (w_win_id == REQ_W'(NUM_REQ - 1)) ? '0 : w_win_id + 1'b1;
        end
    end
`endif

    assign w_idx = bus.req_idx[int'(w_win_id)*IDX_W +: IDX_W];
    assign w_op  = bus.req_op[int'(w_win_id)*2 +: 2];
    assign w_oor = ({1'b0, w_idx} >= (IDX_W+1)'(NUM_FF));

    // One-hot ready for the winner only
    always_comb begin
        bus.req_ready = '0;
        if (w_win_vld) bus.req_ready[w_win_id] = 1'b1;
    end

    // Enable only the addressed cell; an out-of-range index matches none
    always_comb begin
        w_en = '0;
        for (int c = 0; c < NUM_FF; c++) begin
            w_en[c] = w_win_vld && (w_idx == IDX_W'(c));
        end
    end

    for (genvar g = 0; g < NUM_FF; g++) begin : g_cell
        jk_cell u_cell (
            .clk (clk),
            .rst (rst),
            .en  (w_en[g]),
            .j   (w_op[1]),
            .k   (w_op[0]),
            .q   (w_q[g])
        );
    end

    // Grant status and out-of-range pulse for the accepted command
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant_vld <= 1'b0;
            r_grant_id  <= '0;
            r_err_oor   <= 1'b0;
        end else begin
            r_grant_vld <= w_win_vld;
            r_err_oor   <= w_win_vld && w_oor;
            if (w_win_vld) r_grant_id <= w_win_id;
        end
    end

    assign bus.q         = w_q;
    assign bus.grant_vld = r_grant_vld;
    assign bus.grant_id  = r_grant_id;
    assign bus.err_oor   = r_err_oor;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// tb_jk_bank_arbiter: drives an 8-cell and a 6-cell bank with the same
// requester traffic and compares both against a behavioural model.
module tb_jk_bank_arbiter;

    localparam int NR = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    jk_bank_arbiter_if #(.NUM_REQ(NR), .NUM_FF(8)) bus8 ();
    jk_bank_arbiter_if #(.NUM_REQ(NR), .NUM_FF(6)) bus6 ();

    jk_bank_arbiter #(.NUM_REQ(NR), .NUM_FF(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
    jk_bank_arbiter #(.NUM_REQ(NR), .NUM_FF(6)) u_dut6 (.clk(clk), .rst(rst), .bus(bus6.slave));

    int n_chk = 0;
    int n_err = 0;

    // requester stimulus state
    bit s_vld [NR];
    int s_idx [NR];
    int s_op  [NR];

    // model state
    bit m8 [8];
    bit m6 [6];
    int m_ptr = 0;
    bit m_gv  = 0;
    int m_gid = 0;
    bit m_err6 = 0;
    int last_w;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick();
        int start;
`ifdef JK_ARB_FIXED_PRIO_EN
        start = 0;
`else
        start = m_ptr;
`endif
        for (int i = 0; i < NR; i++) begin
            if (s_vld[(start + i) % NR]) return (start + i) % NR;
        end
        return -1;
    endfunction

    function automatic bit jk_apply(input bit q, input int op);
        case (op)
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return ~q;
            default: return q;
        endcase
    endfunction

    task automatic drive();
        for (int r = 0; r < NR; r++) begin
            bus8.req_valid[r]        = s_vld[r];
            bus8.req_idx[r*3 +: 3]   = 3'(s_idx[r]);
            bus8.req_op[r*2 +: 2]    = 2'(s_op[r]);
            bus6.req_valid[r]        = s_vld[r];
            bus6.req_idx[r*3 +: 3]   = 3'(s_idx[r]);
            bus6.req_op[r*2 +: 2]    = 2'(s_op[r]);
        end
    endtask

    // One cycle: drive, check ready, advance model at the edge, check state.
    task automatic step();
        int w;
        logic [7:0] e8;
        logic [5:0] e6;
        drive();
        #1;
        w = rst ? -1 : pick();
        last_w = w;
        chk("ready8", 32'(bus8.req_ready), (w >= 0) ? (32'd1 << w) : 32'd0);
        chk("ready6", 32'(bus6.req_ready), (w >= 0) ? (32'd1 << w) : 32'd0);
        @(posedge clk);
        if (rst) begin
            foreach (m8[i]) m8[i] = 1'b0;
            foreach (m6[i]) m6[i] = 1'b0;
            m_ptr = 0; m_gv = 0; m_gid = 0; m_err6 = 0;
            foreach (s_vld[r]) s_vld[r] = 1'b0;
        end else if (w >= 0) begin
            m_gv = 1; m_gid = w;
            m8[s_idx[w]] = jk_apply(m8[s_idx[w]], s_op[w]);
            if (s_idx[w] < 6) begin
                m6[s_idx[w]] = jk_apply(m6[s_idx[w]], s_op[w]);
                m_err6 = 0;
            end else begin
                m_err6 = 1;
            end
            m_ptr = (w + 1) % NR;
            s_vld[w] = 1'b0;
        end else begin
            m_gv = 0; m_err6 = 0;
        end
        #1;
        for (int i = 0; i < 8; i++) e8[i] = m8[i];
        for (int i = 0; i < 6; i++) e6[i] = m6[i];
        chk("q8", 32'(bus8.q), 32'(e8));
        chk("q6", 32'(bus6.q), 32'(e6));
        chk("gvld8", 32'(bus8.grant_vld), 32'(m_gv));
        chk("gvld6", 32'(bus6.grant_vld), 32'(m_gv));
        if (m_gv || rst) begin
            chk("gid8", 32'(bus8.grant_id), 32'(m_gid));
            chk("gid6", 32'(bus6.grant_id), 32'(m_gid));
        end
        chk("oor8", 32'(bus8.err_oor), 32'd0);
        chk("oor6", 32'(bus6.err_oor), 32'(m_err6));
        @(negedge clk);
    endtask

    task automatic req(input int r, input int idx, input int op);
        s_vld[r] = 1'b1; s_idx[r] = idx; s_op[r] = op;
    endtask

    initial begin
        rst = 1'b1;
        foreach (s_vld[r]) begin s_vld[r] = 0; s_idx[r] = 0; s_op[r] = 0; end
        drive();
        @(negedge clk);

        // reset with every requester valid
        for (int c = 0; c < 2; c++) begin
            for (int r = 0; r < NR; r++) req(r, r, 2);
            step();
        end
        rst = 1'b0;
        chk("rst_q", 32'(bus8.q), 32'h00);
        chk("rst_gvld", 32'(bus8.grant_vld), 32'd0);
        chk("rst_gid", 32'(bus8.grant_id), 32'd0);

        // single requester on cell 3: set, toggle, reset
        req(2, 3, 2); step();
        chk("single_set", 32'(bus8.q), 32'h08);
        chk("single_id", 32'(bus8.grant_id), 32'd2);
        req(2, 3, 3); step();
        chk("single_tgl", 32'(bus8.q), 32'h00);
        req(2, 3, 1); step();
        chk("single_rst", 32'(bus8.q), 32'h00);
        chk("single_id2", 32'(bus8.grant_id), 32'd2);

`ifndef JK_ARB_FIXED_PRIO_EN
        // pointer now 3; a hold from r3 brings it back to 0
        req(3, 0, 0); step();
        for (int c = 0; c < 8; c++) begin
            for (int r = 0; r < NR; r++) req(r, r, 0);
            step();
            chk("rr_seq", 32'(bus8.grant_id), 32'(c % 4));
        end
        foreach (s_vld[r]) s_vld[r] = 1'b0;

        // move pointer to 2, then only r1 and r3 compete
        req(1, 0, 0); step();
        begin
            int exp_seq [3] = '{3, 1, 3};
            for (int c = 0; c < 3; c++) begin
                if (!s_vld[1]) req(1, 1, 0);
                if (!s_vld[3]) req(3, 2, 0);
                step();
                chk("skip_seq", 32'(bus8.grant_id), 32'(exp_seq[c]));
            end
        end
        foreach (s_vld[r]) s_vld[r] = 1'b0;
`else
        // r0 and r3 continuously valid: r0 wins every time
        for (int c = 0; c < 6; c++) begin
            req(0, 1, 0); req(3, 2, 0);
            step();
            chk("fixed_id", 32'(bus8.grant_id), 32'd0);
        end
        foreach (s_vld[r]) s_vld[r] = 1'b0;
`endif

        // same-cell collision: two toggles on cell 5
        req(0, 5, 3); req(1, 5, 3);
        step();
        chk("coll_first", 32'(bus8.q[5]), 32'd1);
        step();
        chk("coll_second", 32'(bus8.q[5]), 32'd0);

        // out-of-range on the 6-cell bank
        req(0, 7, 2); step();
        chk("oor_pulse", 32'(bus6.err_oor), 32'd1);
        chk("oor_q6", 32'(bus6.q), 32'h00);
        step();
        chk("oor_clear", 32'(bus6.err_oor), 32'd0);

        // fill the bank, then reset while r1 waits
        for (int i = 0; i < 8; i++) begin req(0, i, 2); step(); end
        chk("fill", 32'(bus8.q), 32'hFF);
        rst = 1'b1; req(1, 2, 1); step();
        chk("mid_rst_q", 32'(bus8.q), 32'h00);
        req(1, 2, 2); step();
        rst = 1'b0;

        // randomized traffic with occasional resets
        for (int c = 0; c < 800; c++) begin
            rst = ($urandom_range(63) == 0);
            for (int r = 0; r < NR; r++) begin
                if (!s_vld[r] && $urandom_range(1) == 1)
                    req(r, $urandom_range(7), $urandom_range(3));
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
